pipelined_control_unit: RTL

- Parametrised, registered successor to the single-cycle 8-bit decoder.
- Accepts instruction words over a valid/ready handshake and decodes opcode and register fields.
- Supports a two-word load-immediate and a HALT/resume state.
- Drives registered control outputs (ALU op, register addresses, write enable, immediate) to the datapath with one-cycle latency.

---
 rtl/ctrl_pkg.sv | 25 ++
 rtl/instr_decode.sv | 61 ++++++
 rtl/pipelined_control_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcode, ALU-op and FSM state definitions for the control unit
package ctrl_pkg;

    // Opcode values; users cast them to their own OPC_W.
    localparam int OPC_AND  = 0;
    localparam int OPC_OR   = 1;
    localparam int OPC_ADD  = 2;
    localparam int OPC_SUB  = 3;
    localparam int OPC_NOP  = 4;
    localparam int OPC_LDI  = 5;
    localparam int OPC_HALT = 6;

    // ALU operation codes; users cast them to their own ALU_OP_W (zero-extended).
    localparam int ALU_AND = 0;
    localparam int ALU_OR  = 1;
    localparam int ALU_ADD = 2;
    localparam int ALU_SUB = 3;

    typedef enum logic [1:0] {
        S_DECODE = 2'd0,
        S_IMM    = 2'd1,
        S_HALT   = 2'd2
    } state_e;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational opcode/field decoder producing the control bundle
module instr_decode
    import ctrl_pkg::*;
#(
    parameter int OPC_W    = 4,
    parameter int ADDR_W   = 4,
    parameter int ALU_OP_W = 2
) (
    input  logic [OPC_W-1:0]    opc,
    input  logic [ADDR_W-1:0]   fld,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic                wr_enable,
    output logic                is_ldi,
    output logic                is_halt,
    output logic                is_illegal
);

    // Map the opcode to ALU op and flags; register fields pass straight through.
    always_comb begin
        alu_op     = '0;
        rd_addr    = fld;
        wr_addr    = fld;
        wr_enable  = 1'b0;
        is_ldi     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opc)
            OPC_W'(OPC_AND): begin
                alu_op    = ALU_OP_W'(ALU_AND);
                wr_enable = 1'b1;
            end
            OPC_W'(OPC_OR): begin
                alu_op    = ALU_OP_W'(ALU_OR);
                wr_enable = 1'b1;
            end
            OPC_W'(OPC_ADD): begin
                alu_op    = ALU_OP_W'(ALU_ADD);
                wr_enable = 1'b1;
            end
            OPC_W'(OPC_SUB): begin
                alu_op    = ALU_OP_W'(ALU_SUB);
                wr_enable = 1'b1;
            end
            OPC_W'(OPC_NOP): begin
                alu_op = ALU_OP_W'(ALU_AND);
            end
            OPC_W'(OPC_LDI): begin
                is_ldi = 1'b1;
            end
            OPC_W'(OPC_HALT): begin
                is_halt = 1'b1;
            end
            default: begin
                is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - handshaked instruction decoder with LDI/HALT FSM and registered outputs
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPC_W    = 4,
    parameter int ADDR_W   = 4,
    parameter int ALU_OP_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [OPC_W+ADDR_W-1:0]   instr_data,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic                      stall,
    input  logic                      resume,
    output logic                      out_valid,
    output logic [ALU_OP_W-1:0]       alu_op,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic                      wr_enable,
    output logic                      imm_sel,
    output logic [OPC_W+ADDR_W-1:0]   imm_data,
    output logic                      illegal,
    output logic                      halted
);

    localparam int INSTR_W = OPC_W + ADDR_W;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     ldi_addr_q, ldi_addr_d;
    logic                  out_valid_q, out_valid_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic                  wr_enable_q, wr_enable_d;
    logic                  imm_sel_q, imm_sel_d;
    logic [INSTR_W-1:0]    imm_data_q, imm_data_d;
    logic                  illegal_q, illegal_d;

    logic [OPC_W-1:0]      opc;
    logic [ADDR_W-1:0]     fld;
    logic [ALU_OP_W-1:0]   dec_alu_op;
    logic [ADDR_W-1:0]     dec_rd_addr;
    logic [ADDR_W-1:0]     dec_wr_addr;
    logic                  dec_wr_enable;
    logic                  dec_is_ldi;
    logic                  dec_is_halt;
    logic                  dec_is_illegal;
    logic                  xfer;

    assign opc = instr_data[INSTR_W-1 -: OPC_W];
    assign fld = instr_data[ADDR_W-1:0];

    // Ready depends only on reset, stall and state, never on instr_valid.
    assign instr_ready = !rst && !stall && (state_q != S_HALT);
    assign xfer        = instr_valid && instr_ready;

    instr_decode #(
        .OPC_W    (OPC_W),
        .ADDR_W   (ADDR_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .opc        (opc),
        .fld        (fld),
        .alu_op     (dec_alu_op),
        .rd_addr    (dec_rd_addr),
        .wr_addr    (dec_wr_addr),
        .wr_enable  (dec_wr_enable),
        .is_ldi     (dec_is_ldi),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    // Next state and next outputs: pulses clear by default, fields hold, stall freezes everything.
    always_comb begin
        state_d     = state_q;
        ldi_addr_d  = ldi_addr_q;
        alu_op_d    = alu_op_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        imm_data_d  = imm_data_q;
        out_valid_d = 1'b0;
        wr_enable_d = 1'b0;
        imm_sel_d   = 1'b0;
        illegal_d   = 1'b0;
        if (stall) begin
            out_valid_d = out_valid_q;
            wr_enable_d = wr_enable_q;
            imm_sel_d   = imm_sel_q;
            illegal_d   = illegal_q;
        end else begin
            case (state_q)
                S_DECODE: begin
                    if (xfer) begin
                        if (dec_is_ldi) begin
                            // First LDI word: remember the target register, wait for the immediate.
                            ldi_addr_d = dec_wr_addr;
                            state_d    = S_IMM;
                        end else if (dec_is_illegal) begin
                            illegal_d = 1'b1;
                        end else begin
                            // ALU ops, NOP and HALT all complete with an out_valid pulse.
                            out_valid_d = 1'b1;
                            alu_op_d    = dec_alu_op;
                            rd_addr_d   = dec_rd_addr;
                            wr_addr_d   = dec_wr_addr;
                            wr_enable_d = dec_wr_enable;
                            if (dec_is_halt) begin
                                state_d = S_HALT;
                            end
                        end
                    end
                end
                S_IMM: begin
                    if (xfer) begin
                        // Raw immediate word: never decoded as an opcode.
                        out_valid_d = 1'b1;
                        wr_enable_d = 1'b1;
                        imm_sel_d   = 1'b1;
                        imm_data_d  = instr_data;
                        wr_addr_d   = ldi_addr_q;
                        rd_addr_d   = ldi_addr_q;
                        alu_op_d    = '0;
                        state_d     = S_DECODE;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        state_d = S_DECODE;
                    end
                end
                default: begin
                    state_d = S_DECODE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset taking priority over stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_DECODE;
            ldi_addr_q  <= '0;
            out_valid_q <= 1'b0;
            alu_op_q    <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_enable_q <= 1'b0;
            imm_sel_q   <= 1'b0;
            imm_data_q  <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ldi_addr_q  <= ldi_addr_d;
            out_valid_q <= out_valid_d;
            alu_op_q    <= alu_op_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_enable_q <= wr_enable_d;
            imm_sel_q   <= imm_sel_d;
            imm_data_q  <= imm_data_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_op    = alu_op_q;
    assign rd_addr   = rd_addr_q;
    assign wr_addr   = wr_addr_q;
    assign wr_enable = wr_enable_q;
    assign imm_sel   = imm_sel_q;
    assign imm_data  = imm_data_q;
    assign illegal   = illegal_q;
    assign halted    = (state_q == S_HALT);

endmodule
